// File: rtl/regdest_pkg.sv
// Shared definitions for the destination-register tracker family.
//   - SEL_* : encoding of the destination select input
//   - state_t : tracker FSM states
package regdest_pkg;

  localparam logic [1:0] SEL_RT   = 2'd0;
  localparam logic [1:0] SEL_RD   = 2'd1;
  localparam logic [1:0] SEL_RS   = 2'd2;
  localparam logic [1:0] SEL_LINK = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/regdest_sel.sv
// Combinational 4:1 destination-address select.
//   sel       : 0 rt, 1 rd, 2 rs, 3 fixed link register
//   rt/rd/rs  : instruction register fields
//   addr      : selected destination address
module regdest_sel
  import regdest_pkg::*;
#(
  parameter int AW       = 4,
  parameter int LINK_REG = 7
) (
  input  logic [1:0]    sel,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] LINK = AW'(LINK_REG);

  always_comb begin
    addr = LINK;
    case (sel)
      SEL_RT:  addr = rt;
      SEL_RD:  addr = rd;
      SEL_RS:  addr = rs;
      default: addr = LINK;
    endcase
  end

endmodule

// File: rtl/regdest_tracker.sv
// Registered destination-register tracker for the multicycle datapath.
// Latches the selected destination at decode, holds it through EX/MEM,
// and fires a one-cycle register-file write strobe at writeback.
//   clk, rst_n        : clock, async active-low reset
//   sel, rt, rd, rs   : destination select and instruction fields
//   cap_en/wb_en/flush: capture / writeback / cancel controls
//   chk_a, chk_b      : source addresses checked for RAW hazard
//   wa, reg_we        : register-file write port
//   pending, busy     : held-destination flag and one-hot scoreboard
//   hazard            : a source matches the busy destination
//   err               : sticky protocol error
module regdest_tracker
  import regdest_pkg::*;
#(
  parameter int AW           = 4,
  parameter int LINK_REG     = 7,
  parameter int ZERO_PROTECT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           sel,
  input  logic [AW-1:0]        rt,
  input  logic [AW-1:0]        rd,
  input  logic [AW-1:0]        rs,
  input  logic                 cap_en,
  input  logic                 wb_en,
  input  logic                 flush,
  input  logic [AW-1:0]        chk_a,
  input  logic [AW-1:0]        chk_b,
  output logic [AW-1:0]        wa,
  output logic                 reg_we,
  output logic                 pending,
  output logic [(2**AW)-1:0]   busy,
  output logic                 hazard,
  output logic                 err
);

  localparam int NREG = 2**AW;

  state_t        r_state, w_nxt;
  logic [AW-1:0] r_wa, w_sel_addr;
  logic          r_err, w_cap, w_err_set, w_zero_blk;

  regdest_sel #(.AW(AW), .LINK_REG(LINK_REG)) u_sel (
    .sel (sel),
    .rt  (rt),
    .rd  (rd),
    .rs  (rs),
    .addr(w_sel_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cap     = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (wb_en) w_err_set = 1'b1;
        if (cap_en) begin
          w_cap = 1'b1;
          w_nxt = HELD;
        end
      end
      HELD: begin
        // writeback wins over flush; a new capture here is a protocol error
        if (wb_en)       w_nxt = WB;
        else if (flush)  w_nxt = IDLE;
        else if (cap_en) w_err_set = 1'b1;
      end
      WB: begin
        // back-to-back: next instruction's destination captured without a bubble
        if (cap_en) begin
          w_cap = 1'b1;
          w_nxt = HELD;
        end else begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_cap)     r_wa  <= w_sel_addr;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // register 0 is hard-wired when protected: never busy, never written
  assign w_zero_blk = (ZERO_PROTECT != 0) && (r_wa == '0);

  // decoded from registered state so reset truncates the strobe immediately
  assign pending = (r_state != IDLE);
  assign reg_we  = (r_state == WB) && !w_zero_blk;
  assign busy    = (pending && !w_zero_blk) ? (NREG'(1) << r_wa) : '0;
  assign hazard  = busy[chk_a] | busy[chk_b];
  assign wa      = r_wa;
  assign err     = r_err;

endmodule

// File: tb/tb_regdest_tracker.sv
// Self-checking bench: two trackers (register 0 unprotected / protected)
// share one stimulus stream. A transaction-level reference model predicts
// the held destination and queues every expected register-file write; a
// negedge monitor pops the queues whenever a write strobe appears.
module tb_regdest_tracker;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sel;
  logic [AW-1:0] rt, rd, rs, chk_a, chk_b;
  logic cap_en, wb_en, flush;

  logic [1:0][AW-1:0] wa_o;
  logic [1:0][15:0]   busy_o;
  logic [1:0]         we_o, pend_o, haz_o, err_o;

  always #5 clk = ~clk;

  regdest_tracker #(.AW(AW), .LINK_REG(7), .ZERO_PROTECT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rt(rt), .rd(rd), .rs(rs),
    .cap_en(cap_en), .wb_en(wb_en), .flush(flush), .chk_a(chk_a), .chk_b(chk_b),
    .wa(wa_o[0]), .reg_we(we_o[0]), .pending(pend_o[0]), .busy(busy_o[0]),
    .hazard(haz_o[0]), .err(err_o[0]));

  regdest_tracker #(.AW(AW), .LINK_REG(7), .ZERO_PROTECT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rt(rt), .rd(rd), .rs(rs),
    .cap_en(cap_en), .wb_en(wb_en), .flush(flush), .chk_a(chk_a), .chk_b(chk_b),
    .wa(wa_o[1]), .reg_we(we_o[1]), .pending(pend_o[1]), .busy(busy_o[1]),
    .hazard(haz_o[1]), .err(err_o[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pend: an instruction's destination is outstanding (incl. its write cycle)
  // m_wb  : the outstanding destination is being written this cycle
  typedef struct { int due; logic [AW-1:0] a; } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  bit            m_pend[2], m_wb[2], m_err[2];
  logic [AW-1:0] m_dst[2];
  int            cyc = 0;

  function automatic bit suppressed(int k);
    return (k == 1) && (m_dst[k] == 0);
  endfunction

  function automatic logic [15:0] exp_busy(int k);
    if (m_pend[k] && !suppressed(k)) return 16'(1) << m_dst[k];
    return 16'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_wb[k] = 0; m_err[k] = 0; m_dst[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    logic [AW-1:0] addr;
    wr_t w;
    cyc++;
    addr = (sel == 2'd0) ? rt : (sel == 2'd1) ? rd : (sel == 2'd2) ? rs : 4'd7;
    for (int k = 0; k < 2; k++) begin
      if (!m_pend[k]) begin
        if (wb_en) m_err[k] = 1;
        if (cap_en) begin m_pend[k] = 1; m_dst[k] = addr; end
      end else if (m_wb[k]) begin
        m_wb[k] = 0;
        if (cap_en) m_dst[k] = addr;
        else        m_pend[k] = 0;
      end else begin
        if (wb_en) begin
          m_wb[k] = 1;
          if (!suppressed(k)) begin
            w.due = cyc; w.a = m_dst[k];
            if (k == 0) q0.push_back(w); else q1.push_back(w);
          end
        end else if (flush) m_pend[k] = 0;
        else if (cap_en)    m_err[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] b;
    for (int k = 0; k < 2; k++) begin
      b = exp_busy(k);
      chk($sformatf("pending%0d", k), pend_o[k], m_pend[k]);
      chk($sformatf("wa%0d", k), wa_o[k], m_dst[k]);
      chk($sformatf("busy%0d", k), busy_o[k], b);
      chk($sformatf("hazard%0d", k), haz_o[k], b[chk_a] | b[chk_b]);
      chk($sformatf("err%0d", k), err_o[k], m_err[k]);
    end
  endtask

  // ---------------- write-strobe monitor ----------------
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (we_o[0]) begin
        if (q0.size() == 0) chk("we0_spurious", we_o[0], 0);
        else begin
          e = q0.pop_front();
          chk("we0_cycle", cyc, e.due);
          chk("we0_wa", wa_o[0], e.a);
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        chk("we0_missing", we_o[0], 1);
      end
      if (we_o[1]) begin
        if (q1.size() == 0) chk("we1_spurious", we_o[1], 0);
        else begin
          e = q1.pop_front();
          chk("we1_cycle", cyc, e.due);
          chk("we1_wa", wa_o[1], e.a);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        chk("we1_missing", we_o[1], 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  // one call = one cycle; entered and left 1 time unit after a rising edge
  task automatic cycle(input logic [1:0] s, input logic [AW-1:0] t, d, r,
                       input logic c, w, f, input logic [AW-1:0] a, b);
    sel = s; rt = t; rd = d; rs = r;
    cap_en = c; wb_en = w; flush = f; chk_a = a; chk_b = b;
    #3;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] a = 4'd0, input logic [AW-1:0] b = 4'd0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, a, b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("reset_we0", we_o[0], 0);
    chk("reset_we1", we_o[1], 0);
    rst_n = 1'b1;
  endtask

  initial begin
    sel = 0; rt = 0; rd = 0; rs = 0; cap_en = 0; wb_en = 0; flush = 0;
    chk_a = 0; chk_b = 0;
    do_reset();

    // capture rd = 9, hazard queries
    cycle(2'd1, 4'd0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(4'd9, 4'd0);
    chk("plan_busy9", busy_o[0], 16'h0200);
    chk("plan_haz9", haz_o[0], 1);
    idle(4'd3, 4'd5);
    chk("plan_haz35", haz_o[0], 0);
    // writeback
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); idle();

    // link select, back-to-back capture during writeback
    cycle(2'd3, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("plan_link_wa", wa_o[0], 7);
    cycle(2'd0, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(4'd2, 4'd0);
    chk("plan_b2b_busy", busy_o[0], 16'h0004);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); idle();

    // flush, then writeback+flush together
    cycle(2'd2, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0);
    idle(4'd5, 4'd5);
    chk("plan_flush_busy", busy_o[0], 16'h0000);
    cycle(2'd2, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    idle(); idle();

    // protocol errors
    chk("plan_err_clear", err_o[0], 0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle();
    chk("plan_err_wb_idle", err_o[0], 1);
    do_reset();
    cycle(2'd1, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(2'd1, 4'd0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); idle();
    chk("plan_err_cap_held", err_o[0], 1);
    chk("plan_wa_kept", wa_o[0], 4);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); idle();

    // register 0 protection, then reset in the middle of a write cycle
    do_reset();
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(4'd0, 4'd0);
    chk("plan_zp_busy", busy_o[1], 16'h0000);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); idle();
    cycle(2'd0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("plan_mid_wb_we0", we_o[0], 1);
    chk("plan_mid_wb_we1", we_o[1], 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_we0", we_o[0], 0);
    chk("rst_async_we1", we_o[1], 0);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] t, d, r;
      t = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      if (i == 1500) do_reset();
      cycle(2'($urandom), t, d, r,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, 4'($urandom), 4'($urandom));
    end
    cycle(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); idle(); idle();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
